// File: rtl/w0rm_bus_responder_pkg.sv
// Shared definitions for the W0RM bus responder: FSM state encoding,
// STATUS word bit positions, default window base and the data value
// returned on error/write responses.
package w0rm_bus_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int STAT_RW_BIT    = 1;
  localparam int STAT_ALIGN_BIT = 2;
  localparam int STAT_DROP_BIT  = 3;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
  localparam logic [31:0] ERR_RESP_DATA     = 32'h0;

  // STATUS = {28'b0, drop_err, align_err, rw_err, 1'b0}
  function automatic logic [31:0] status_word(input logic drop, input logic align,
                                              input logic rw);
    status_word                 = '0;
    status_word[STAT_DROP_BIT]  = drop;
    status_word[STAT_ALIGN_BIT] = align;
    status_word[STAT_RW_BIT]    = rw;
  endfunction

endpackage

// File: rtl/w0rm_bus_regbank.sv
// Register bank behind the responder: NUM_REGS words, one write port and
// one read port sharing the same index, plus a flat view of every word.
//  clk, reset : clock, synchronous active-high reset (clears all words)
//  we         : write enable, word idx takes wdata at the clock edge
//  idx        : word index for both read and write
//  wdata      : write data
//  rdata      : combinational read of word idx
//  regs_o     : word k at [DATA_WIDTH*k +: DATA_WIDTH]
module w0rm_bus_regbank #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [IDX_W-1:0]               idx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem;

  // NUM_REGS is a power of two, so every idx value names a real word.
  always_ff @(posedge clk) begin
    if (reset)   mem      <= '0;
    else if (we) mem[idx] <= wdata;
  end

  assign rdata  = mem[idx];
  assign regs_o = mem;

endmodule

// File: rtl/w0rm_bus_responder.sv
// Target end of the W0RM core bus. Decodes a window of NUM_REGS data words
// plus a read-only STATUS word, accepts one request at a time, inserts
// WAIT_STATES cycles and returns a one-cycle Data/Valid response.
//  clk, reset      : clock, synchronous active-high reset
//  bus_addr_i      : byte address        bus_data_i  : write data
//  bus_read_i      : read qualifier      bus_write_i : write qualifier
//  bus_valid_i     : one-cycle request strobe
//  bus_data_o      : read data, 0 whenever bus_valid_o is low
//  bus_valid_o     : one-cycle response strobe (read data / write ack)
//  bus_error_o     : sticky OR of the STATUS error flags
//  regs_o          : flat view of the data registers
module w0rm_bus_responder
  import w0rm_bus_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 2,
  parameter int          DATA_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    bus_addr_i,
  input  logic [DATA_WIDTH-1:0]          bus_data_i,
  input  logic                           bus_read_i,
  input  logic                           bus_write_i,
  input  logic                           bus_valid_i,
  output logic [DATA_WIDTH-1:0]          bus_data_o,
  output logic                           bus_valid_o,
  output logic                           bus_error_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int          IDX_W      = $clog2(NUM_REGS);
  localparam logic [31:0] STATUS_OFF = 32'(NUM_REGS * 4);
  localparam logic [3:0]  WCNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                  state_q, state_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic [IDX_W-1:0]        lat_idx;
  logic                    lat_status, lat_rd, lat_wr, lat_bad;
  logic [DATA_WIDTH-1:0]   lat_data;
  logic                    rw_err_q, align_err_q, drop_err_q;
  logic [DATA_WIDTH-1:0]   rd_data;

  // Unsigned offset: anything below BASE_ADDR wraps high and falls outside.
  logic [31:0] off;
  logic        in_win, req_hit, accept, resp, reg_we;

  assign off     = bus_addr_i - BASE_ADDR;
  assign in_win  = (off <= STATUS_OFF);
  assign req_hit = bus_valid_i & in_win;
  assign accept  = (state_q == ST_IDLE) & req_hit & (bus_read_i | bus_write_i);
  assign resp    = (state_q == ST_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        wcnt_d  = WCNT_INIT;
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd0) state_d = ST_RESP;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch and sticky error flags. Protocol errors are recorded at
  // accept; the request itself is still answered, just without side effects.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_idx     <= '0;
      lat_status  <= 1'b0;
      lat_rd      <= 1'b0;
      lat_wr      <= 1'b0;
      lat_bad     <= 1'b0;
      lat_data    <= '0;
      rw_err_q    <= 1'b0;
      align_err_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        lat_idx    <= off[IDX_W+1:2];
        lat_status <= (off == STATUS_OFF);
        lat_rd     <= bus_read_i;
        lat_wr     <= bus_write_i;
        lat_bad    <= (bus_read_i & bus_write_i) | (|off[1:0]);
        lat_data   <= bus_data_i;
        if (bus_read_i & bus_write_i) rw_err_q    <= 1'b1;
        if (|off[1:0])                align_err_q <= 1'b1;
      end
      // Any in-window strobe while busy (including the RESP cycle) is lost.
      if (req_hit && state_q != ST_IDLE) drop_err_q <= 1'b1;
    end
  end

  // Write lands on the edge that ends RESP, so the read path in RESP never
  // sees a half-finished update.
  assign reg_we = resp & lat_wr & ~lat_bad & ~lat_status;

  w0rm_bus_regbank #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_regbank (
    .clk   (clk),
    .reset (reset),
    .we    (reg_we),
    .idx   (lat_idx),
    .wdata (lat_data),
    .rdata (rd_data),
    .regs_o(regs_o)
  );

  assign bus_valid_o = resp;
  assign bus_data_o  = (resp && lat_rd && !lat_bad)
                     ? (lat_status ? status_word(drop_err_q, align_err_q, rw_err_q) : rd_data)
                     : ERR_RESP_DATA;
  // Driven only from flag flops, so it is as clean as a registered output.
  assign bus_error_o = drop_err_q | align_err_q | rw_err_q;

endmodule

// File: tb/tb_w0rm_bus_responder.sv
module tb_w0rm_bus_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          NR   = 16;
  localparam int          WS   = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [31:0]       bus_addr_i = '0, bus_data_i = '0;
  logic              bus_read_i = 1'b0, bus_write_i = 1'b0, bus_valid_i = 1'b0;
  logic [31:0]       bus_data_o, d0_data_o;
  logic              bus_valid_o, bus_error_o, d0_valid_o, d0_error_o;
  logic [NR*32-1:0]  regs_o, d0_regs_o;

  always #5 clk = ~clk;

  w0rm_bus_responder #(.BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_STATES(WS), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i),
    .bus_read_i(bus_read_i), .bus_write_i(bus_write_i), .bus_valid_i(bus_valid_i),
    .bus_data_o(bus_data_o), .bus_valid_o(bus_valid_o), .bus_error_o(bus_error_o),
    .regs_o(regs_o));

  // Zero-wait-state instance on the same request stream; checked only in the
  // early directed steps where both see identical histories.
  w0rm_bus_responder #(.BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_STATES(0), .DATA_WIDTH(32)) dut0 (
    .clk(clk), .reset(reset), .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i),
    .bus_read_i(bus_read_i), .bus_write_i(bus_write_i), .bus_valid_i(bus_valid_i),
    .bus_data_o(d0_data_o), .bus_valid_o(d0_valid_o), .bus_error_o(d0_error_o),
    .regs_o(d0_regs_o));

  // Reference model: register contents and sticky error flags.
  logic [31:0] ref_regs [NR];
  bit          ref_rw, ref_align, ref_drop;
  int          n_pass = 0, n_total = 0;

  function automatic logic [31:0] ref_status();
    return {28'b0, ref_drop, ref_align, ref_rw, 1'b0};
  endfunction

  function automatic logic ref_err();
    return ref_drop | ref_align | ref_rw;
  endfunction

  task automatic ref_reset();
    for (int k = 0; k < NR; k++) ref_regs[k] = '0;
    ref_rw = 0; ref_align = 0; ref_drop = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One request from IDLE. inj = cycle (1..WS+1 after accept) in which a
  // second in-window request is thrown at the busy responder; chk0 also
  // checks the zero-wait instance responds in the first cycle after accept.
  task automatic txn(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr,
                     input int inj, input bit chk0);
    logic [31:0] off, rv;
    bit          acc, bad, is_st;
    int          idx;
    off   = a - BASE;
    acc   = (off <= 32'(NR * 4)) && (rd || wr);
    is_st = (off == 32'(NR * 4));
    idx   = int'(off[5:2]);
    bad   = (rd && wr) || (off[1:0] != 2'b00);
    bus_addr_i = a; bus_data_i = d; bus_read_i = rd; bus_write_i = wr; bus_valid_i = 1'b1;
    tick();
    bus_valid_i = 1'b0; bus_read_i = 1'b0; bus_write_i = 1'b0;
    if (!acc) begin
      for (int i = 0; i < WS + 2; i++) begin
        check("ign_valid", {31'b0, bus_valid_o}, 32'd0);
        check("ign_data", bus_data_o, 32'd0);
        check("ign_err", {31'b0, bus_error_o}, {31'b0, ref_err()});
        tick();
      end
      return;
    end
    if (rd && wr) ref_rw = 1;
    if (off[1:0] != 2'b00) ref_align = 1;
    for (int i = 1; i <= WS + 1; i++) begin
      rv = (rd && !bad) ? (is_st ? ref_status() : ref_regs[idx]) : 32'd0;
      check("valid", {31'b0, bus_valid_o}, {31'b0, i == WS + 1});
      check("data", bus_data_o, (i == WS + 1) ? rv : 32'd0);
      check("err", {31'b0, bus_error_o}, {31'b0, ref_err()});
      if (chk0 && i == 1) begin
        check("ws0_valid", {31'b0, d0_valid_o}, 32'd1);
        check("ws0_data", d0_data_o, rv);
      end else if (chk0 && i == 2) begin
        check("ws0_valid_after", {31'b0, d0_valid_o}, 32'd0);
      end
      if (i == inj) begin
        bus_addr_i = BASE + 32'(4 * $urandom_range(0, NR - 1));
        bus_read_i = 1'b1; bus_valid_i = 1'b1;
      end
      tick();
      if (i == inj) begin
        bus_valid_i = 1'b0; bus_read_i = 1'b0;
        ref_drop = 1;
      end
    end
    if (wr && !bad && !is_st) ref_regs[idx] = d;
    if (!is_st) check("reg_after", regs_o[idx*32 +: 32], ref_regs[idx]);
    check("valid_idle", {31'b0, bus_valid_o}, 32'd0);
    check("err_after", {31'b0, bus_error_o}, {31'b0, ref_err()});
  endtask

  initial begin
    logic [31:0] a, d;
    int          kind, op, inj;
    bit          rd, wr;
    ref_reset();
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_valid", {31'b0, bus_valid_o}, 32'd0);
    check("rst_data", bus_data_o, 32'd0);
    check("rst_err", {31'b0, bus_error_o}, 32'd0);
    check("rst_regs_lo", regs_o[31:0], 32'd0);
    check("rst_ws0_valid", {31'b0, d0_valid_o}, 32'd0);

    // Directed steps
    txn(32'h8000_0008, 32'h1234_5678, 1'b0, 1'b1, 0, 1'b1);
    check("reg2_written", regs_o[95:64], 32'h1234_5678);
    check("ws0_reg2", d0_regs_o[95:64], 32'h1234_5678);
    txn(32'h8000_0008, 32'h0, 1'b1, 1'b0, 0, 1'b1);
    txn(32'h8000_0040, 32'h0, 1'b1, 1'b0, 0, 1'b1);
    txn(32'h8000_0006, 32'h0, 1'b1, 1'b0, 0, 1'b1);
    txn(32'h8000_0040, 32'h0, 1'b1, 1'b0, 0, 1'b0);
    txn(32'h8000_0014, 32'hCAFE_F00D, 1'b0, 1'b1, 1, 1'b0);
    check("drop_reg5", regs_o[191:160], 32'hCAFE_F00D);
    txn(32'h8000_0040, 32'h0, 1'b1, 1'b0, 0, 1'b0);
    txn(32'h8000_0010, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, 1'b0);
    check("rw_no_write", regs_o[159:128], 32'd0);
    txn(32'h8000_0040, 32'h0, 1'b1, 1'b0, 0, 1'b0);
    txn(32'h0000_1000, 32'h5555_AAAA, 1'b1, 1'b0, 0, 1'b0);
    txn(32'h8000_0044, 32'h5555_AAAA, 1'b0, 1'b1, 0, 1'b0);
    txn(32'h8000_0020, 32'h5555_AAAA, 1'b0, 1'b0, 0, 1'b0);
    txn(32'h8000_0040, 32'h7777_7777, 1'b0, 1'b1, 3, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        6:       a = BASE + 32'(NR * 4);
        7:       a = BASE + 32'(4 * $urandom_range(0, NR - 1) + $urandom_range(1, 3));
        8:       a = $urandom & 32'h7fff_ffff;
        9:       a = BASE + 32'(NR * 4 + 4 + 4 * $urandom_range(0, 100));
        default: a = BASE + 32'(4 * $urandom_range(0, NR - 1));
      endcase
      op = $urandom_range(0, 9);
      rd = (op == 0) || (op >= 2 && op <= 5);
      wr = (op == 0) || (op >= 6);
      d  = $urandom;
      inj = ($urandom_range(0, 5) == 0) ? $urandom_range(1, WS + 1) : 0;
      txn(a, d, rd, wr, inj, 1'b0);
      if ($urandom_range(0, 3) == 0) tick();
    end
    for (int k = 0; k < NR; k++) check("rand_regs", regs_o[k*32 +: 32], ref_regs[k]);

    // Reset in the middle of a write
    bus_addr_i = 32'h8000_000C; bus_data_i = 32'hDEAD_BEEF;
    bus_write_i = 1'b1; bus_valid_i = 1'b1;
    tick();
    bus_valid_i = 1'b0; bus_write_i = 1'b0;
    check("mid_valid", {31'b0, bus_valid_o}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ref_reset();
    for (int i = 0; i < WS + 3; i++) begin
      check("postrst_valid", {31'b0, bus_valid_o}, 32'd0);
      tick();
    end
    check("postrst_reg3", regs_o[127:96], 32'd0);
    check("postrst_err", {31'b0, bus_error_o}, 32'd0);
    for (int k = 0; k < NR; k++) check("postrst_regs", regs_o[k*32 +: 32], ref_regs[k]);
    txn(32'h8000_0040, 32'h0, 1'b1, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
